// File: rtl/memory_transaction_stage.sv
// Memory transaction stage of the rv32i pipeline: takes the execute closure,
// performs at most one data-memory access on a valid/ready request bus with a
// separate response channel, and produces the writeback closure.

package memory_transaction_stage_pkg;

   typedef enum logic [1:0] {
      REG_WRITE_FROM_COMPUTE   = 2'd0,
      REG_WRITE_FROM_MEMORY    = 2'd1,
      REG_WRITE_FROM_PC_PLUS_4 = 2'd2,
      REG_WRITE_FROM_IMMEDIATE = 2'd3
   } reg_write_source_t;

   typedef struct packed {
      logic              enable;
      logic [4:0]        which_register;
      reg_write_source_t source;
   } compute_reg_control_t;

endpackage

module memory_transaction_stage
   import memory_transaction_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  compute_reg_control_t in_register_control,
   input  logic [XLEN-1:0]      in_compute_result,
   input  logic                 in_mem_enable,
   input  logic                 in_mem_write,
   input  logic [1:0]           in_mem_size,
   input  logic                 in_mem_unsigned,
   input  logic [XLEN-1:0]      in_mem_addr,
   input  logic [XLEN-1:0]      in_mem_w_data,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_write,
   output logic [XLEN-1:0]      mem_req_addr,
   output logic [XLEN-1:0]      mem_req_w_data,
   output logic [3:0]           mem_req_byte_en,
   input  logic                 mem_resp_valid,
   input  logic [XLEN-1:0]      mem_resp_data,
   output logic                 stage_5_writeback_closure_valid,
   output compute_reg_control_t stage_5_writeback_register_control,
   output logic [XLEN-1:0]      stage_5_writeback_compute_result,
   output logic [XLEN-1:0]      stage_5_writeback_memory_r_data,
   output logic                 misalign_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 req_write_q, req_write_d;
   logic [XLEN-1:0]      req_addr_q, req_addr_d;
   logic [XLEN-1:0]      req_w_data_q, req_w_data_d;
   logic [3:0]           req_byte_en_q, req_byte_en_d;
   logic [1:0]           ld_size_q, ld_size_d;
   logic                 ld_unsigned_q, ld_unsigned_d;
   logic [1:0]           ld_offset_q, ld_offset_d;
   compute_reg_control_t pend_ctrl_q, pend_ctrl_d;
   logic [XLEN-1:0]      pend_result_q, pend_result_d;
   logic                 out_valid_q, out_valid_d;
   compute_reg_control_t out_ctrl_q, out_ctrl_d;
   logic [XLEN-1:0]      out_result_q, out_result_d;
   logic [XLEN-1:0]      out_r_data_q, out_r_data_d;
   logic                 fault_q, fault_d;

   logic                 misaligned;
   logic [XLEN-1:0]      lane_w_data;
   logic [3:0]           lane_byte_en;
   logic [XLEN-1:0]      load_shifted;
   logic [XLEN-1:0]      load_ext;

   // Size 3 is treated as a word access, so it shares the word alignment rule.
   always_comb begin
      misaligned = 1'b0;
      case (in_mem_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = in_mem_addr[0];
         default: misaligned = (in_mem_addr[1:0] != 2'b00);
      endcase
   end

   // Replicate store data across the lanes and enable only the lanes being written.
   always_comb begin
      lane_w_data  = in_mem_w_data;
      lane_byte_en = 4'b1111;
      case (in_mem_size)
         2'd0: begin
            lane_w_data  = {4{in_mem_w_data[7:0]}};
            lane_byte_en = 4'b0001 << in_mem_addr[1:0];
         end
         2'd1: begin
            lane_w_data  = {2{in_mem_w_data[15:0]}};
            lane_byte_en = 4'b0011 << {in_mem_addr[1], 1'b0};
         end
         default: begin
            lane_w_data  = in_mem_w_data;
            lane_byte_en = 4'b1111;
         end
      endcase
   end

   // Bring the addressed bytes of the raw load word down to bit 0 and extend them.
   always_comb begin
      load_shifted = mem_resp_data >> {ld_offset_q, 3'b000};
      load_ext     = load_shifted;
      case (ld_size_q)
         2'd0:    load_ext = {{(XLEN-8){load_shifted[7] & ~ld_unsigned_q}}, load_shifted[7:0]};
         2'd1:    load_ext = {{(XLEN-16){load_shifted[15] & ~ld_unsigned_q}}, load_shifted[15:0]};
         default: load_ext = load_shifted;
      endcase
   end

   // Next-state logic: accept closures in IDLE, run the bus handshake, and emit
   // exactly one writeback closure per accepted input.
   always_comb begin
      state_d       = state_q;
      req_write_d   = req_write_q;
      req_addr_d    = req_addr_q;
      req_w_data_d  = req_w_data_q;
      req_byte_en_d = req_byte_en_q;
      ld_size_d     = ld_size_q;
      ld_unsigned_d = ld_unsigned_q;
      ld_offset_d   = ld_offset_q;
      pend_ctrl_d   = pend_ctrl_q;
      pend_result_d = pend_result_q;
      out_valid_d   = 1'b0;
      out_ctrl_d    = out_ctrl_q;
      out_result_d  = out_result_q;
      out_r_data_d  = out_r_data_q;
      fault_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!in_mem_enable) begin
                  out_valid_d  = 1'b1;
                  out_ctrl_d   = in_register_control;
                  out_result_d = in_compute_result;
                  out_r_data_d = '0;
               end else if (misaligned) begin
                  out_valid_d       = 1'b1;
                  out_ctrl_d        = in_register_control;
                  out_ctrl_d.enable = 1'b0;
                  out_result_d      = in_compute_result;
                  out_r_data_d      = '0;
                  fault_d           = 1'b1;
               end else begin
                  pend_ctrl_d   = in_register_control;
                  pend_result_d = in_compute_result;
                  req_write_d   = in_mem_write;
                  req_addr_d    = {in_mem_addr[XLEN-1:2], 2'b00};
                  req_w_data_d  = in_mem_write ? lane_w_data : '0;
                  req_byte_en_d = in_mem_write ? lane_byte_en : 4'b1111;
                  ld_size_d     = in_mem_size;
                  ld_unsigned_d = in_mem_unsigned;
                  ld_offset_d   = in_mem_addr[1:0];
                  state_d       = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               if (req_write_q) begin
                  out_valid_d  = 1'b1;
                  out_ctrl_d   = pend_ctrl_q;
                  out_result_d = pend_result_q;
                  out_r_data_d = '0;
                  state_d      = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (mem_resp_valid) begin
               out_valid_d  = 1'b1;
               out_ctrl_d   = pend_ctrl_q;
               out_result_d = pend_result_q;
               out_r_data_d = load_ext;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and closure registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         req_write_q   <= 1'b0;
         req_addr_q    <= '0;
         req_w_data_q  <= '0;
         req_byte_en_q <= 4'b0000;
         ld_size_q     <= 2'd0;
         ld_unsigned_q <= 1'b0;
         ld_offset_q   <= 2'd0;
         pend_ctrl_q   <= '0;
         pend_result_q <= '0;
         out_valid_q   <= 1'b0;
         out_ctrl_q    <= '0;
         out_result_q  <= '0;
         out_r_data_q  <= '0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_write_q   <= req_write_d;
         req_addr_q    <= req_addr_d;
         req_w_data_q  <= req_w_data_d;
         req_byte_en_q <= req_byte_en_d;
         ld_size_q     <= ld_size_d;
         ld_unsigned_q <= ld_unsigned_d;
         ld_offset_q   <= ld_offset_d;
         pend_ctrl_q   <= pend_ctrl_d;
         pend_result_q <= pend_result_d;
         out_valid_q   <= out_valid_d;
         out_ctrl_q    <= out_ctrl_d;
         out_result_q  <= out_result_d;
         out_r_data_q  <= out_r_data_d;
         fault_q       <= fault_d;
      end
   end

   // in_ready is also held low while reset is asserted so every output reads 0.
   assign in_ready                           = (state_q == IDLE) && !reset;
   assign mem_req_valid                      = (state_q == REQ);
   assign mem_req_write                      = req_write_q;
   assign mem_req_addr                       = req_addr_q;
   assign mem_req_w_data                     = req_w_data_q;
   assign mem_req_byte_en                    = req_byte_en_q;
   assign stage_5_writeback_closure_valid    = out_valid_q;
   assign stage_5_writeback_register_control = out_ctrl_q;
   assign stage_5_writeback_compute_result   = out_result_q;
   assign stage_5_writeback_memory_r_data    = out_r_data_q;
   assign misalign_fault                     = fault_q;

endmodule
